usbfs_link_ctrl: RTL and testbench

- Link-level controller that sequences the USB FS bit-level transceiver.
- Owns the D+ pull-up (connect) and the transceiver's active-low reset.
- Monitors raw line state for bus reset, suspend and resume.
- Gates the packet layer's response request into the transceiver's tx_sta turnaround window (rx_fin cycle + 0..3).
- Sits between the packet/protocol layer and usbfs_bitlevel. Clock is 60 MHz.

---
 rtl/usbfs_link_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_usbfs_link_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usbfs_link_ctrl.sv
// USB FS link controller: attach sequencing, bus reset / suspend / resume detection
// and gating of packet-layer responses into the transceiver turnaround window.

module usbfs_link_ctrl #(
   parameter int CONNECT_CYCLES   = 60000,
   parameter int RESET_SE0_CYCLES = 150,
   parameter int SUSPEND_CYCLES   = 180000,
   parameter int RESUME_K_CYCLES  = 4,
   parameter int TX_WINDOW        = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       connect_req,
   input  logic       usb_dp_rx,
   input  logic       usb_dn_rx,
   input  logic       xcvr_oe,
   input  logic       xcvr_rx_fin,
   input  logic       resp_valid,
   output logic       usb_pullup,
   output logic       xcvr_rstn,
   output logic       xcvr_tx_sta,
   output logic       resp_drop,
   output logic       bus_reset,
   output logic       suspended,
   output logic       resume_pulse,
   output logic [2:0] link_state
);

   localparam int CONN_W      = $clog2(CONNECT_CYCLES + 1);
   localparam int SE0_W       = $clog2(RESET_SE0_CYCLES + 1);
   localparam int IDLE_W      = $clog2(SUSPEND_CYCLES + 1);
   localparam int K_W         = $clog2(RESUME_K_CYCLES + 1);
   localparam int WIN_W       = $clog2(TX_WINDOW + 1);
   localparam int LATE_CYCLES = 8;
   localparam int LATE_W      = $clog2(LATE_CYCLES);

   typedef enum logic [2:0] {
      DISCONN   = 3'd0,
      CONN_WAIT = 3'd1,
      ACTIVE    = 3'd2,
      BUSRST    = 3'd3,
      SUSPEND   = 3'd4,
      RESUME    = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic                dp_meta_q, dp_meta_d, dp_sync_q, dp_sync_d;
   logic                dn_meta_q, dn_meta_d, dn_sync_q, dn_sync_d;
   logic [CONN_W-1:0]   conn_cnt_q, conn_cnt_d;
   logic [SE0_W-1:0]    se0_cnt_q, se0_cnt_d;
   logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [K_W-1:0]      k_cnt_q, k_cnt_d;
   logic                se0_seen_q, se0_seen_d;
   logic                win_open_q, win_open_d;
   logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
   logic                late_open_q, late_open_d;
   logic [LATE_W-1:0]   late_cnt_q, late_cnt_d;
   logic                resp_prev_q, resp_prev_d;

   logic                line_j, line_k, line_se0, se0_hit, resp_rise, win_live;
   logic [WIN_W-1:0]    win_pos;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= DISCONN;
         dp_meta_q   <= 1'b0;
         dp_sync_q   <= 1'b0;
         dn_meta_q   <= 1'b0;
         dn_sync_q   <= 1'b0;
         conn_cnt_q  <= '0;
         se0_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         k_cnt_q     <= '0;
         se0_seen_q  <= 1'b0;
         win_open_q  <= 1'b0;
         win_cnt_q   <= '0;
         late_open_q <= 1'b0;
         late_cnt_q  <= '0;
         resp_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dp_meta_q   <= dp_meta_d;
         dp_sync_q   <= dp_sync_d;
         dn_meta_q   <= dn_meta_d;
         dn_sync_q   <= dn_sync_d;
         conn_cnt_q  <= conn_cnt_d;
         se0_cnt_q   <= se0_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         k_cnt_q     <= k_cnt_d;
         se0_seen_q  <= se0_seen_d;
         win_open_q  <= win_open_d;
         win_cnt_q   <= win_cnt_d;
         late_open_q <= late_open_d;
         late_cnt_q  <= late_cnt_d;
         resp_prev_q <= resp_prev_d;
      end
   end

   // Line decode uses only the second synchronizer stage; SE1 feeds no counter.
   always_comb begin
      dp_meta_d   = usb_dp_rx;
      dp_sync_d   = dp_meta_q;
      dn_meta_d   = usb_dn_rx;
      dn_sync_d   = dn_meta_q;
      resp_prev_d = resp_valid;
      line_j      = dp_sync_q & ~dn_sync_q;
      line_k      = ~dp_sync_q & dn_sync_q;
      line_se0    = ~dp_sync_q & ~dn_sync_q;
      se0_hit     = line_se0 && (se0_cnt_q >= SE0_W'(RESET_SE0_CYCLES - 1));
   end

   always_comb begin
      se0_cnt_d = '0;
      if (line_se0) begin
         se0_cnt_d = (se0_cnt_q == SE0_W'(RESET_SE0_CYCLES)) ? se0_cnt_q : se0_cnt_q + SE0_W'(1);
      end
      idle_cnt_d = '0;
      if (line_j && !xcvr_oe) begin
         idle_cnt_d = (idle_cnt_q == IDLE_W'(SUSPEND_CYCLES)) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
      end
      k_cnt_d = '0;
      if (line_k) begin
         k_cnt_d = (k_cnt_q == K_W'(RESUME_K_CYCLES)) ? k_cnt_q : k_cnt_q + K_W'(1);
      end

      state_d      = state_q;
      conn_cnt_d   = '0;
      se0_seen_d   = 1'b0;
      usb_pullup   = 1'b1;
      xcvr_rstn    = 1'b0;
      bus_reset    = 1'b0;
      suspended    = 1'b0;
      resume_pulse = 1'b0;

      case (state_q)
         DISCONN: begin
            usb_pullup = 1'b0;
            if (connect_req) state_d = CONN_WAIT;
         end
         CONN_WAIT: begin
            if (conn_cnt_q == CONN_W'(CONNECT_CYCLES - 1)) state_d = ACTIVE;
            else conn_cnt_d = conn_cnt_q + CONN_W'(1);
         end
         ACTIVE: begin
            xcvr_rstn = 1'b1;
            if (line_j && !xcvr_oe && (idle_cnt_q >= IDLE_W'(SUSPEND_CYCLES - 1))) state_d = SUSPEND;
         end
         BUSRST: begin
            bus_reset = 1'b1;
            if (!line_se0) begin
               state_d    = ACTIVE;
               idle_cnt_d = '0;
               k_cnt_d    = '0;
            end
         end
         SUSPEND: begin
            suspended = 1'b1;
            if (line_k && (k_cnt_q >= K_W'(RESUME_K_CYCLES - 1))) state_d = RESUME;
         end
         RESUME: begin
            suspended  = 1'b1;
            se0_seen_d = se0_seen_q | line_se0;
            if (line_j && se0_seen_q) begin
               state_d      = ACTIVE;
               resume_pulse = 1'b1;
            end
         end
         default: state_d = DISCONN;
      endcase

      // Detach wins over everything; a long SE0 wins over any in-state transition.
      if (!connect_req) begin
         state_d      = DISCONN;
         resume_pulse = 1'b0;
      end else if (se0_hit && (state_q == ACTIVE || state_q == SUSPEND || state_q == RESUME)) begin
         state_d      = BUSRST;
         resume_pulse = 1'b0;
      end
   end

   // Turnaround window (offsets 0..TX_WINDOW) then an 8-cycle late window for drop reporting.
   always_comb begin
      win_open_d  = 1'b0;
      win_cnt_d   = '0;
      late_open_d = 1'b0;
      late_cnt_d  = '0;
      xcvr_tx_sta = 1'b0;
      resp_drop   = 1'b0;
      resp_rise   = resp_valid & ~resp_prev_q;
      win_live    = xcvr_rx_fin | win_open_q;
      win_pos     = xcvr_rx_fin ? '0 : win_cnt_q;
      if (state_q == ACTIVE) begin
         if (win_live) begin
            if (resp_valid && !xcvr_oe) begin
               xcvr_tx_sta = 1'b1;
            end else if (win_pos == WIN_W'(TX_WINDOW)) begin
               late_open_d = 1'b1;
            end else begin
               win_open_d = 1'b1;
               win_cnt_d  = win_pos + WIN_W'(1);
            end
         end else if (late_open_q) begin
            if (resp_rise) begin
               resp_drop = 1'b1;
            end else if (late_cnt_q != LATE_W'(LATE_CYCLES - 1)) begin
               late_open_d = 1'b1;
               late_cnt_d  = late_cnt_q + LATE_W'(1);
            end
         end
      end
   end

   assign link_state = state_q;

endmodule

// File: tb/tb_usbfs_link_ctrl.sv
// Directed + randomized bench for usbfs_link_ctrl with shortened timing parameters;
// response-gate expectations come from an offset-based model of the turnaround rules.

module tb_usbfs_link_ctrl;

   localparam int CONN = 600;
   localparam int RSE0 = 150;
   localparam int SUSP = 1800;
   localparam int RK   = 4;
   localparam int TXW  = 3;
   localparam int LATE = 8;

   logic       clk;
   logic       rst;
   logic       connect_req;
   logic       usb_dp_rx;
   logic       usb_dn_rx;
   logic       xcvr_oe;
   logic       xcvr_rx_fin;
   logic       resp_valid;
   logic       usb_pullup;
   logic       xcvr_rstn;
   logic       xcvr_tx_sta;
   logic       resp_drop;
   logic       bus_reset;
   logic       suspended;
   logic       resume_pulse;
   logic [2:0] link_state;

   int vectors;
   int miscompares;

   usbfs_link_ctrl #(
      .CONNECT_CYCLES  (CONN),
      .RESET_SE0_CYCLES(RSE0),
      .SUSPEND_CYCLES  (SUSP),
      .RESUME_K_CYCLES (RK),
      .TX_WINDOW       (TXW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .connect_req (connect_req),
      .usb_dp_rx   (usb_dp_rx),
      .usb_dn_rx   (usb_dn_rx),
      .xcvr_oe     (xcvr_oe),
      .xcvr_rx_fin (xcvr_rx_fin),
      .resp_valid  (resp_valid),
      .usb_pullup  (usb_pullup),
      .xcvr_rstn   (xcvr_rstn),
      .xcvr_tx_sta (xcvr_tx_sta),
      .resp_drop   (resp_drop),
      .bus_reset   (bus_reset),
      .suspended   (suspended),
      .resume_pulse(resume_pulse),
      .link_state  (link_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic dp, input logic dn, input logic oe,
                                input logic fin, input logic rv);
      usb_dp_rx   = dp;
      usb_dn_rx   = dn;
      xcvr_oe     = oe;
      xcvr_rx_fin = fin;
      resp_valid  = rv;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      checkOutput(tag, 32'(observed), 32'(expected));
   endtask

   task automatic checkLink(input string tag, input int st, input logic pu,
                            input logic rn, input logic br, input logic sp);
      checkOutput({tag, ".link_state"}, 32'(link_state), st);
      checkBit({tag, ".usb_pullup"}, usb_pullup, pu);
      checkBit({tag, ".xcvr_rstn"}, xcvr_rstn, rn);
      checkBit({tag, ".bus_reset"}, bus_reset, br);
      checkBit({tag, ".suspended"}, suspended, sp);
   endtask

   int   r, d, pulses, extra, len;
   logic oe_f, fin, rv, exp_tx, exp_drop;

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      connect_req = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();

      // Reset: everything quiet, even with a pending rx_fin/resp_valid.
      connect_req = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkLink("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkBit("reset.tx_sta", xcvr_tx_sta, 1'b0);
      checkBit("reset.resp_drop", resp_drop, 1'b0);
      checkBit("reset.resume_pulse", resume_pulse, 1'b0);
      tick();
      checkOutput("reset_held.link_state", 32'(link_state), 0);

      // Attach: CONN_WAIT at cycle 1, ACTIVE exactly CONN cycles later.
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkLink("conn_entry", 1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (9) tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (CONN - 10) tick();
      checkLink("conn_last", 1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkLink("conn_active", 2, 1'b1, 1'b1, 1'b0, 1'b0);

      // SE0 shorter than a bus reset: exact boundary then a random shorter run.
      for (int t = 0; t < 2; t++) begin
         len = (t == 0) ? RSE0 - 1 : $urandom_range(RSE0 - 2, 1);
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         repeat (len) tick();
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         repeat (4) tick();
         checkLink("short_se0", 2, 1'b1, 1'b1, 1'b0, 1'b0);
      end

      // Full bus reset: SE0 raw for RSE0 cycles, then J.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (RSE0) tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkLink("busrst_pre", 2, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      checkLink("busrst", 3, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      checkLink("busrst_exit", 2, 1'b1, 1'b1, 1'b0, 1'b0);

      // Response gate: random offset of resp_valid from the (last) rx_fin.
      for (int t = 0; t < 30; t++) begin
         r    = (t == 0) ? TXW : (t == 1) ? TXW + 1 : $urandom_range(0, 16);
         oe_f = (t > 1) && ($urandom_range(0, 3) == 0);
         d    = (t > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, TXW) : 0;
         for (int g = 0; g < 2; g++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkBit("gap.tx_sta", xcvr_tx_sta, 1'b0);
            checkBit("gap.resp_drop", resp_drop, 1'b0);
            tick();
         end
         for (int i = 0; i < 22; i++) begin
            fin      = (i == 0) || (d != 0 && i == d);
            rv       = (r <= 15) && (i >= d + r);
            exp_tx   = !oe_f && (r <= TXW) && (i == d + r);
            exp_drop = (r > TXW) && (r <= TXW + LATE) && (i == d + r);
            applyStimulus(1'b1, 1'b0, oe_f, fin, rv);
            checkBit("gate.tx_sta", xcvr_tx_sta, exp_tx);
            checkBit("gate.resp_drop", resp_drop, exp_drop);
            tick();
         end
      end

      // Idle masking while the device drives, then exact suspend timing after oe falls.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (SUSP - 10) tick();
      checkLink("oe_mask", 2, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (SUSP - 1) tick();
      checkLink("suspend_pre", 2, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      checkLink("suspend", 4, 1'b1, 1'b0, 1'b0, 1'b1);

      // Short K glitch must not resume.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (RK - 1) tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (6) tick();
      checkLink("k_glitch", 4, 1'b1, 1'b0, 1'b0, 1'b1);

      // Resume: long K, 2-cycle SE0, then J.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (RK + 1) tick();
      checkLink("resume_pre", 4, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      checkLink("resume", 5, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (24) tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      pulses = 0;
      for (int i = 32; i <= 37; i++) begin
         checkBit("resume_pulse", resume_pulse, i == 34);
         pulses += int'(resume_pulse);
         if (i == 35) checkLink("resume_done", 2, 1'b1, 1'b1, 1'b0, 1'b0);
         tick();
      end
      checkOutput("resume_pulse_count", pulses, 1);

      // Detach while in bus reset.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (RSE0 + 2) tick();
      checkLink("busrst2", 3, 1'b1, 1'b0, 1'b1, 1'b0);
      extra = $urandom_range(0, 20);
      repeat (extra) tick();
      checkLink("busrst2_held", 3, 1'b1, 1'b0, 1'b1, 1'b0);
      connect_req = 1'b0;
      tick();
      checkLink("detach", 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reattach, open a window, then reset: the window must not survive.
      connect_req = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      repeat (CONN) tick();
      checkLink("reattach", 2, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checkBit("rst_window.tx_sta", xcvr_tx_sta, 1'b0);
      checkLink("rst_mid", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
